// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises echo-path FIFO bytes onto TXD.
// Frame = start, DATA_WIDTH bits LSB first, optional parity, stop bits.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_tx,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_tx,
  output logic                  txd,
  output logic                  busy,
  output logic                  done_tx,
  output logic                  load_err
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_PEN   = CNT_W'(CPB - 2);
  localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_q;
  logic                    txd_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    load_err_q;

  logic accept;
  logic bit_end;
  logic stop_end;
  logic par_d;
  logic load_err_d;

  assign accept   = load & en_tx;
  assign bit_end  = (cnt_q == CNT_LAST);
  assign stop_end = (state_q == STOP) && bit_end &&
                    (idx_q == STOP_LAST);
  assign par_d    = (PARITY == 1) ? ~^data_tx : ^data_tx;

  // Loads are legal only in IDLE, LOAD, or the final stop clk
  assign load_err_d = load & (~en_tx |
                      ~((state_q == IDLE) ||
                        (state_q == LOAD) || stop_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      load_err_q <= load_err_d;
      unique case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (accept) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          shift_q <= data_tx;
          par_q   <= par_d;
          txd_q   <= 1'b0;
          cnt_q   <= '0;
          idx_q   <= '0;
          state_q <= START;
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == BIT_LAST) begin
              idx_q <= '0;
              if (PARITY != 0) begin
                txd_q   <= par_q;
                state_q <= PAR;
              end else begin
                txd_q   <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PAR: begin
          if (bit_end) begin
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          txd_q <= 1'b1;
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == STOP_LAST) begin
              idx_q <= '0;
              if (accept) begin
                state_q <= LOAD;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            // Registered done_tx: arm it one clk before the last stop clk
            if ((cnt_q == CNT_PEN) && (idx_q == STOP_LAST))
              done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign done_tx  = done_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four parity/stop configurations at 16 clks/bit,
// each frame checked clk by clk against a bit-list model of the line.
module tb_uart_tx_frame;

  localparam int CPB = 16;
  localparam int NI  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_v      [NI];
  logic       load_v    [NI];
  logic [7:0] data_v    [NI];
  logic       txd_v     [NI];
  logic       busy_v    [NI];
  logic       done_v    [NI];
  logic       lerr_v    [NI];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_frame #(
      .DATA_WIDTH(8),
      .CLK_FREQ  (16),
      .BAUD      (1),
      .PARITY    (g == 1 ? 2 : (g == 2 ? 1 : 0)),
      .STOP_BITS (g == 3 ? 2 : 1)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_tx   (en_v[g]),
      .load    (load_v[g]),
      .data_tx (data_v[g]),
      .txd     (txd_v[g]),
      .busy    (busy_v[g]),
      .done_tx (done_v[g]),
      .load_err(lerr_v[g])
    );
  end

  function automatic int par_of(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction

  function automatic int stops_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int i, input string tag);
    chk({tag, "_txd"}, 32'(txd_v[i]), 32'd1);
    chk({tag, "_busy"}, 32'(busy_v[i]), 32'd0);
    chk({tag, "_done"}, 32'(done_v[i]), 32'd0);
  endtask

  // Starts in the LOAD clk (load was high the clk before).
  task automatic frame(input int i, input logic [7:0] d,
                       input bit chain, input int pert_t,
                       input int abort_t);
    bit q[$];
    int ones;
    int len;
    load_v[i] = 1'b0;
    data_v[i] = d;
    chk("load_txd", 32'(txd_v[i]), 32'd1);
    chk("load_busy", 32'(busy_v[i]), 32'd1);
    chk("load_err0", 32'(lerr_v[i]), 32'd0);
    tick();
    data_v[i] = 8'($urandom);
    q.push_back(1'b0);
    for (int b = 0; b < 8; b++) q.push_back(d[b]);
    ones = $countones(d);
    if (par_of(i) == 2) q.push_back(1'(ones % 2));
    if (par_of(i) == 1) q.push_back(1'(1 - ones % 2));
    for (int s = 0; s < stops_of(i); s++) q.push_back(1'b1);
    len = q.size() * CPB;
    for (int t = 0; t < len; t++) begin
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        chk_idle(i, "async_rst");
        return;
      end
      chk($sformatf("txd_i%0d_t%0d", i, t), 32'(txd_v[i]),
          32'(q[t / CPB]));
      chk($sformatf("done_i%0d_t%0d", i, t), 32'(done_v[i]),
          32'(t == len - 1));
      chk($sformatf("busy_i%0d_t%0d", i, t), 32'(busy_v[i]), 32'd1);
      chk($sformatf("lerr_i%0d_t%0d", i, t), 32'(lerr_v[i]),
          32'(pert_t >= 0 && t == pert_t + 1));
      load_v[i] = (t == pert_t) || (chain && t == len - 1);
      tick();
    end
    if (!chain) begin
      chk_idle(i, "post_frame");
      chk("post_lerr", 32'(lerr_v[i]), 32'd0);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d);
    load_v[i] = 1'b1;
    data_v[i] = 8'($urandom);
    tick();
    frame(i, d, 1'b0, -1, -1);
  endtask

  initial begin
    int inst;
    int nb;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      en_v[i]   = 1'b1;
      load_v[i] = 1'b0;
      data_v[i] = 8'($urandom);
    end
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      chk_idle(i, "reset");
      chk("reset_lerr", 32'(lerr_v[i]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    send(0, 8'h55);

    load_v[0] = 1'b1;
    tick();
    frame(0, 8'h0A, 1'b1, -1, -1);
    frame(0, 8'hA5, 1'b0, -1, -1);

    send(1, 8'h07);
    send(2, 8'h07);

    load_v[0] = 1'b1;
    tick();
    frame(0, 8'h3C, 1'b0, 3 * CPB + 7, -1);

    en_v[0]   = 1'b0;
    load_v[0] = 1'b1;
    tick();
    chk("dis_lerr", 32'(lerr_v[0]), 32'd1);
    chk_idle(0, "dis");
    load_v[0] = 1'b0;
    en_v[0]   = 1'b1;
    tick();
    chk("dis_lerr_end", 32'(lerr_v[0]), 32'd0);
    chk_idle(0, "dis_end");

    load_v[0] = 1'b1;
    tick();
    frame(0, 8'h3C, 1'b0, -1, (1 + 3) * CPB + 5);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle(0, "in_rst");
    end
    rst_n = 1'b1;
    tick();
    chk_idle(0, "rst_rel");
    send(0, 8'hFF);

    send(3, 8'h00);

    for (int k = 0; k < 8; k++) begin
      inst = int'($urandom_range(0, NI - 1));
      nb   = int'($urandom_range(1, 2));
      load_v[inst] = 1'b1;
      tick();
      for (int b = 0; b < nb; b++)
        frame(inst, 8'($urandom), b < nb - 1, -1, -1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
